// File: rtl/tree_adder_sequencer_if.sv
// Handshake/bus bundle between the tree-adder sequencer, the frame controller,
// the TreeAdder array and the shadow-test result consumer.
interface tree_adder_sequencer_if #(
  parameter int unsigned ADDER_DATASIZE = 16,
  parameter int unsigned CMD_WIDTH      = 4,
  parameter int unsigned PASS_W         = 3
);
  logic                      start_valid;
  logic                      start_ready;
  logic [1:0]                src_sel;
  logic [CMD_WIDTH-1:0]      cmd_out;
  logic [ADDER_DATASIZE-1:0] sum_in;
  logic                      result_valid;
  logic                      result_ready;
  logic [ADDER_DATASIZE-1:0] result_data;
  logic                      result_err;
  logic                      busy;
  logic [PASS_W-1:0]         pass_cnt;

  // Sequencer side
  modport master (
    input  start_valid, src_sel, sum_in, result_ready,
    output start_ready, cmd_out, result_valid, result_data, result_err, busy, pass_cnt
  );

  // Environment side (frame controller, array, result consumer)
  modport slave (
    output start_valid, src_sel, sum_in, result_ready,
    input  start_ready, cmd_out, result_valid, result_data, result_err, busy, pass_cnt
  );
endinterface

// File: rtl/tree_adder_sequencer.sv
// Sequences one TreeAdder reduction per job: load a source plane, run log2(side)
// SUM passes, settle, then capture the top-left pixel as the frame sum.
module tree_adder_sequencer #(
  parameter int unsigned IMGSIDELENGTH  = 64,
  parameter int unsigned ADDER_DATASIZE = 16,
  parameter int unsigned CMD_WIDTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  tree_adder_sequencer_if.master bus
);

  localparam int unsigned NUM_PASSES = $clog2(IMGSIDELENGTH);
  localparam int unsigned PASS_W     = $clog2(NUM_PASSES + 1);

  localparam logic [CMD_WIDTH-1:0] CMD_HOLD      = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] CMD_LOAD_MULT = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] CMD_LOAD_SHA  = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] CMD_LOAD_SHB  = CMD_WIDTH'(3);
  localparam logic [CMD_WIDTH-1:0] CMD_SUM       = CMD_WIDTH'(4);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_REDUCE  = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]                state_q, state_d;
  logic [1:0]                src_q, src_d;
  logic [CMD_WIDTH-1:0]      cmd_q, cmd_d;
  logic [PASS_W-1:0]         pass_q, pass_d;
  logic                      rv_q, rv_d;
  logic [ADDER_DATASIZE-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= 2'd0;
      cmd_q   <= CMD_HOLD;
      pass_q  <= PASS_W'(0);
      rv_q    <= 1'b0;
      rdata_q <= ADDER_DATASIZE'(0);
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cmd_q   <= cmd_d;
      pass_q  <= pass_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, plus output values derived from the state being entered
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cmd_d   = CMD_HOLD;
    pass_d  = pass_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_valid && ready_q) begin
          src_d   = bus.src_sel;
          err_d   = (bus.src_sel == 2'd3);
          state_d = S_LOAD;
        end
      end
      S_LOAD:    state_d = S_REDUCE;
      S_REDUCE: begin
        if (pass_q == PASS_W'(NUM_PASSES)) state_d = S_SETTLE;
      end
      S_SETTLE:  state_d = S_CAPTURE;
      S_CAPTURE: begin
        rdata_d = bus.sum_in;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.result_ready) begin
          pass_d  = PASS_W'(0);
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase

    // Illegal source falls back to the mult plane; result_err flags it
    case (state_d)
      S_LOAD: begin
        case (src_d)
          2'd1:    cmd_d = CMD_LOAD_SHA;
          2'd2:    cmd_d = CMD_LOAD_SHB;
          default: cmd_d = CMD_LOAD_MULT;
        endcase
      end
      S_REDUCE: begin
        cmd_d = CMD_SUM;
        if (pass_q < PASS_W'(NUM_PASSES)) pass_d = pass_q + PASS_W'(1);
      end
      default:  cmd_d = CMD_HOLD;
    endcase

    rv_d    = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign bus.start_ready  = ready_q;
  assign bus.cmd_out      = cmd_q;
  assign bus.pass_cnt     = pass_q;
  assign bus.result_valid = rv_q;
  assign bus.result_data  = rdata_q;
  assign bus.result_err   = err_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_tree_adder_sequencer.sv
// Bench for tree_adder_sequencer: default instance (side 64) plus a side-8
// instance for back-to-back throughput, checked against a job-timeline model.
module tb_tree_adder_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tree_adder_sequencer_if #(.ADDER_DATASIZE(16), .CMD_WIDTH(4), .PASS_W(3)) if0 ();
  tree_adder_sequencer_if #(.ADDER_DATASIZE(16), .CMD_WIDTH(4), .PASS_W(2)) if1 ();

  tree_adder_sequencer #(.IMGSIDELENGTH(64), .ADDER_DATASIZE(16), .CMD_WIDTH(4)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  tree_adder_sequencer #(.IMGSIDELENGTH(8), .ADDER_DATASIZE(16), .CMD_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Per-instance views so the model and compare loop can index both DUTs
  logic        sv_a[2], rr_a[2], sr_a[2], rv_a[2], err_a[2], busy_a[2];
  logic [1:0]  ss_a[2];
  logic [3:0]  cmd_a[2];
  logic [15:0] sum_a[2], rd_a[2];
  logic [2:0]  pc_a[2];

  assign sv_a[0] = if0.start_valid;   assign sv_a[1] = if1.start_valid;
  assign rr_a[0] = if0.result_ready;  assign rr_a[1] = if1.result_ready;
  assign ss_a[0] = if0.src_sel;       assign ss_a[1] = if1.src_sel;
  assign sum_a[0] = if0.sum_in;       assign sum_a[1] = if1.sum_in;
  assign sr_a[0] = if0.start_ready;   assign sr_a[1] = if1.start_ready;
  assign rv_a[0] = if0.result_valid;  assign rv_a[1] = if1.result_valid;
  assign err_a[0] = if0.result_err;   assign err_a[1] = if1.result_err;
  assign busy_a[0] = if0.busy;        assign busy_a[1] = if1.busy;
  assign cmd_a[0] = if0.cmd_out;      assign cmd_a[1] = if1.cmd_out;
  assign rd_a[0] = if0.result_data;   assign rd_a[1] = if1.result_data;
  assign pc_a[0] = if0.pass_cnt;      assign pc_a[1] = 3'(if1.pass_cnt);

  // Model: k = cycles since job acceptance (0 when idle)
  int          np[2] = '{6, 3};
  int          k[2];
  bit          active[2];
  logic [1:0]  msrc[2];
  bit          merr[2];
  logic [15:0] mdata[2];
  bit          ready_ok;

  function automatic logic [3:0] exp_cmd(input int kk, input logic [1:0] s, input int n);
    if (kk == 1) return (s == 2'd1) ? 4'h2 : (s == 2'd2) ? 4'h3 : 4'h1;
    if (kk >= 2 && kk <= n + 1) return 4'h4;
    return 4'h0;
  endfunction

  function automatic int exp_pc(input int kk, input int n);
    if (kk <= 1) return 0;
    return (kk - 1 < n) ? kk - 1 : n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        active[i] = 1'b0; k[i] = 0; merr[i] = 1'b0; mdata[i] = 16'h0; msrc[i] = 2'd0;
      end
      ready_ok = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!active[i]) begin
          if (sv_a[i] && ready_ok) begin
            active[i] = 1'b1; k[i] = 1; msrc[i] = ss_a[i]; merr[i] = (ss_a[i] == 2'd3);
          end
        end else if (k[i] < np[i] + 4) begin
          if (k[i] == np[i] + 3) mdata[i] = sum_a[i];
          k[i]++;
        end else if (rr_a[i]) begin
          active[i] = 1'b0; k[i] = 0;
        end
      end
      ready_ok = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d cmd_out", i), 32'(cmd_a[i]), 32'(exp_cmd(k[i], msrc[i], np[i])));
        chk($sformatf("d%0d pass_cnt", i), 32'(pc_a[i]), 32'(exp_pc(k[i], np[i])));
        chk($sformatf("d%0d start_ready", i), 32'(sr_a[i]), 32'(!active[i] && ready_ok));
        chk($sformatf("d%0d busy", i), 32'(busy_a[i]), 32'(active[i]));
        chk($sformatf("d%0d result_valid", i), 32'(rv_a[i]), 32'(active[i] && k[i] >= np[i] + 4));
        chk($sformatf("d%0d result_data", i), 32'(rd_a[i]), 32'(mdata[i]));
        chk($sformatf("d%0d result_err", i), 32'(err_a[i]), 32'(merr[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Launch a job on dut0, check its load code, count SUM cycles and latency to result_valid
  task automatic run_job0(input logic [1:0] s, input logic [3:0] exp_load, input logic [15:0] sumv,
                          output int nsum, output int lat);
    if0.src_sel = s;
    if0.start_valid = 1'b1;
    step();
    lat = 1;
    if0.start_valid = 1'b0;
    if0.src_sel = 2'(s + 2'd1);
    chk("job load code", 32'(if0.cmd_out), 32'(exp_load));
    nsum = 0;
    step(); lat++;
    while (if0.cmd_out == 4'h4 && nsum < 20) begin
      nsum++;
      step(); lat++;
    end
    if0.sum_in = sumv;
    while (!if0.result_valid && lat < 40) begin
      step(); lat++;
    end
    chk("job result_valid reached", 32'(if0.result_valid), 32'd1);
  endtask

  task automatic accept0();
    if0.result_ready = 1'b1;
    step();
    if0.result_ready = 1'b0;
    chk("accept result_valid", 32'(if0.result_valid), 32'd0);
    chk("accept start_ready", 32'(if0.start_ready), 32'd1);
  endtask

  initial begin
    int nsum, lat, loads, sums, rvs, last, gap_bad;
    logic [15:0] held;
    if0.start_valid = 1'b0; if0.src_sel = 2'd0; if0.sum_in = 16'hdead; if0.result_ready = 1'b0;
    if1.start_valid = 1'b0; if1.src_sel = 2'd0; if1.sum_in = 16'h0;    if1.result_ready = 1'b0;

    // 1: reset then idle
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("t1 cmd_out", 32'(if0.cmd_out), 32'h0);
    chk("t1 start_ready", 32'(if0.start_ready), 32'd1);
    chk("t1 result_valid", 32'(if0.result_valid), 32'd0);
    chk("t1 busy", 32'(if0.busy), 32'd0);

    // 2: single mult job with explicit cycle-by-cycle expectations
    if0.src_sel = 2'd0; if0.start_valid = 1'b1;
    step();
    if0.start_valid = 1'b0;
    chk("t2 load", 32'(if0.cmd_out), 32'h1);
    for (int j = 0; j < 6; j++) begin
      step();
      chk("t2 sum", 32'(if0.cmd_out), 32'h4);
      chk("t2 pass_cnt", 32'(if0.pass_cnt), 32'(j + 1));
    end
    step();
    chk("t2 settle hold", 32'(if0.cmd_out), 32'h0);
    if0.sum_in = 16'h1234;
    step();
    chk("t2 no early valid", 32'(if0.result_valid), 32'd0);
    step();
    chk("t2 valid at T+10", 32'(if0.result_valid), 32'd1);
    chk("t2 result_data", 32'(if0.result_data), 32'h1234);
    chk("t2 result_err", 32'(if0.result_err), 32'd0);
    accept0();

    // 3: shadowB with backpressure and ignored start pulses
    if0.sum_in = 16'hdead;
    run_job0(2'd2, 4'h3, 16'h0bee, nsum, lat);
    chk("t3 sum count", 32'(nsum), 32'd6);
    held = if0.result_data;
    chk("t3 captured", 32'(held), 32'h0bee);
    for (int c = 0; c < 20; c++) begin
      if0.start_valid = c[0];
      chk("t3 valid held", 32'(if0.result_valid), 32'd1);
      chk("t3 data stable", 32'(if0.result_data), 32'(held));
      step();
    end
    if0.start_valid = 1'b0;
    accept0();

    // 4: illegal source then a shadowA job
    run_job0(2'd3, 4'h1, 16'h0042, nsum, lat);
    chk("t4 illegal err", 32'(if0.result_err), 32'd1);
    chk("t4 illegal data", 32'(if0.result_data), 32'h0042);
    accept0();
    run_job0(2'd1, 4'h2, 16'hffff, nsum, lat);
    chk("t4 shadowA err", 32'(if0.result_err), 32'd0);
    chk("t4 shadowA data", 32'(if0.result_data), 32'hffff);
    accept0();

    // 5: reset on the third SUM cycle
    if0.src_sel = 2'd0; if0.start_valid = 1'b1;
    step();
    if0.start_valid = 1'b0;
    step(); step(); step();
    chk("t5 third sum", 32'(if0.cmd_out), 32'h4);
    chk("t5 pass before rst", 32'(if0.pass_cnt), 32'd3);
    rst = 1'b1;
    #1;
    chk("t5 cmd after rst", 32'(if0.cmd_out), 32'h0);
    chk("t5 pass after rst", 32'(if0.pass_cnt), 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("t5 no partial result", 32'(if0.result_valid), 32'd0);
      step();
    end
    run_job0(2'd0, 4'h1, 16'h5a5a, nsum, lat);
    chk("t5 full passes", 32'(nsum), 32'd6);
    chk("t5 latency", 32'(lat), 32'd10);
    chk("t5 data", 32'(if0.result_data), 32'h5a5a);
    accept0();

    // 6: back-to-back on the side-8 instance
    if1.result_ready = 1'b1; if1.src_sel = 2'd0; if1.start_valid = 1'b1;
    step();
    loads = 0; sums = 0; rvs = 0; last = -1; gap_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (if1.cmd_out == 4'h1) begin
        if (last >= 0 && c - last != 8) gap_bad++;
        last = c;
        loads++;
      end
      if (if1.cmd_out == 4'h4) sums++;
      if (if1.result_valid) rvs++;
      if1.sum_in = 16'(c * 37);
      if (c == 40) if1.start_valid = 1'b0;
      step();
    end
    chk("t6 jobs", 32'(loads), 32'd5);
    chk("t6 sum cycles", 32'(sums), 32'd15);
    chk("t6 results", 32'(rvs), 32'd5);
    chk("t6 period", 32'(gap_bad), 32'd0);
    chk("t6 last data", 32'(if1.result_data), 32'(16'(38 * 37)));
    step(); step();
    if1.result_ready = 1'b0;
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
